// File: rtl/fpu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fpu_issue_ctrl
// Desc     : Requester-side start/done/busy handshake controller for FPU_Top.
//            Optional WAIT watchdog enabled by defining FPU_ISSUE_TIMEOUT_EN.
// Revision : 1.0  initial release
// ============================================================================
module fpu_issue_ctrl #(
  parameter int TAG_W          = 5,
  parameter int LOCAL_SIGN_OPS = 1,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic             fpu_start,
  output logic [2:0]       fpu_op,
  output logic [31:0]      fpu_n1,
  output logic [31:0]      fpu_n2,
  input  logic [31:0]      fpu_result,
  input  logic             fpu_done,
  input  logic             fpu_busy,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_data,
  output logic [TAG_W-1:0] resp_tag,
  output logic             resp_err
);

  localparam logic [31:0] C_QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               req_ready_q, req_ready_d;
  logic               fpu_start_q, fpu_start_d;
  logic [2:0]         fpu_op_q, fpu_op_d;
  logic [31:0]        fpu_n1_q, fpu_n1_d;
  logic [31:0]        fpu_n2_q, fpu_n2_d;
  logic               resp_valid_q, resp_valid_d;
  logic [31:0]        resp_data_q, resp_data_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic               resp_err_q, resp_err_d;

`ifdef FPU_ISSUE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]   cnt_q, cnt_d;
`endif

  always_comb begin
    state_d     = state_q;
    fpu_start_d = 1'b0;
    fpu_op_d    = fpu_op_q;
    fpu_n1_d    = fpu_n1_q;
    fpu_n2_d    = fpu_n2_q;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;
    tag_d       = tag_q;
`ifdef FPU_ISSUE_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          fpu_op_d = req_op;
          fpu_n1_d = req_a;
          fpu_n2_d = req_b;
          tag_d    = req_tag;
          if (req_op[2:1] == 2'b11) begin
            resp_data_d = C_QNAN;
            resp_err_d  = 1'b1;
            state_d     = S_RESP;
          end else if ((LOCAL_SIGN_OPS != 0) && (req_op == 3'b100)) begin
            resp_data_d = {~req_a[31], req_a[30:0]};
            resp_err_d  = 1'b0;
            state_d     = S_RESP;
          end else if ((LOCAL_SIGN_OPS != 0) && (req_op == 3'b101)) begin
            resp_data_d = req_a;
            resp_err_d  = 1'b0;
            state_d     = S_RESP;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (!fpu_busy) begin
          fpu_start_d = 1'b1;
          state_d     = S_WAIT;
`ifdef FPU_ISSUE_TIMEOUT_EN
          cnt_d       = '0;
`endif
        end
      end
      S_WAIT: begin
        // A done seen while our own start pulse is still high belongs to a previous op.
        if (fpu_done && !fpu_start_q) begin
          resp_data_d = fpu_result;
          resp_err_d  = 1'b0;
          state_d     = S_RESP;
        end
`ifdef FPU_ISSUE_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          resp_data_d = C_QNAN;
          resp_err_d  = 1'b1;
          state_d     = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    req_ready_d  = (state_d == S_IDLE);
    resp_valid_d = (state_d == S_RESP);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      req_ready_q  <= 1'b0;
      fpu_start_q  <= 1'b0;
      fpu_op_q     <= 3'd0;
      fpu_n1_q     <= 32'd0;
      fpu_n2_q     <= 32'd0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= 32'd0;
      tag_q        <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      fpu_start_q  <= fpu_start_d;
      fpu_op_q     <= fpu_op_d;
      fpu_n1_q     <= fpu_n1_d;
      fpu_n2_q     <= fpu_n2_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      tag_q        <= tag_d;
      resp_err_q   <= resp_err_d;
    end
  end

`ifdef FPU_ISSUE_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  assign req_ready  = req_ready_q;
  assign fpu_start  = fpu_start_q;
  assign fpu_op     = fpu_op_q;
  assign fpu_n1     = fpu_n1_q;
  assign fpu_n2     = fpu_n2_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_tag   = tag_q;
  assign resp_err   = resp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_fpu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpu_issue_ctrl
// Desc     : Self-checking bench for fpu_issue_ctrl with a transaction model.
// Revision : 1.0  initial release
// ============================================================================
module tb_fpu_issue_ctrl;

  localparam int TMO = 16;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = 3'd0;
  logic [31:0] req_a = 32'd0;
  logic [31:0] req_b = 32'd0;
  logic [4:0]  req_tag = 5'd0;
  logic        fpu_start;
  logic [2:0]  fpu_op;
  logic [31:0] fpu_n1, fpu_n2;
  logic [31:0] fpu_result;
  logic        fpu_done;
  logic        fpu_busy = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_data;
  logic [4:0]  resp_tag;
  logic        resp_err;

  logic        fdone = 1'b0;
  logic [31:0] fres = 32'hDEAD_BEEF;
  logic        stray_done = 1'b0;
  int          fcnt = 0;
  int          cur_lat = 1;
  bit          cur_stale = 1'b0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  assign fpu_done   = fdone | stray_done;
  assign fpu_result = fres;

  always #5 clk = ~clk;

  fpu_issue_ctrl #(.TAG_W(5), .LOCAL_SIGN_OPS(1), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .fpu_start(fpu_start), .fpu_op(fpu_op), .fpu_n1(fpu_n1), .fpu_n2(fpu_n2),
    .fpu_result(fpu_result), .fpu_done(fpu_done), .fpu_busy(fpu_busy),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_tag(resp_tag), .resp_err(resp_err)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  tag;
    int          lat;
    int          busy;
    int          rr;
    bit          stray;
    bit          stale;
    logic [31:0] exp;
    bit          err;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [4:0] tag, input int lat, input int busy, input int rr,
                              input bit stray, input bit stale, input logic [31:0] exp, input bit err);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.tag = tag; v.lat = lat; v.busy = busy; v.rr = rr;
    v.stray = stray; v.stale = stale; v.exp = exp; v.err = err;
    return v;
  endfunction

  // Stand-in arithmetic for the external FPU: the exact IEEE results for the operands used here.
  function automatic logic [31:0] fpu_fn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op == 3'd0 && a == 32'h40C00000 && b == 32'h40000000) return 32'h41000000;
    if (op == 3'd1 && a == 32'h40C00000 && b == 32'h40000000) return 32'h40800000;
    if (op == 3'd2 && a == 32'h40400000 && b == 32'hC0000000) return 32'hC0C00000;
    if (op == 3'd3 && a == 32'h41100000 && b == 32'h40400000) return 32'h40400000;
    return a ^ b;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  // External FPU: done + result `cur_lat` cycles after the start pulse (0 = never).
  always @(posedge clk) begin
    #2;
    fdone = 1'b0;
    fres  = 32'hDEAD_BEEF;
    if (!rst) begin
      fcnt = 0;
    end else if (fpu_start) begin
      fcnt = cur_lat;
      if (cur_stale) fdone = 1'b1;
    end else if (fcnt > 0) begin
      fcnt--;
      if (fcnt == 0) begin
        fdone = 1'b1;
        fres  = fpu_fn(fpu_op, fpu_n1, fpu_n2);
      end
    end
  end

  // Transaction-level model: one outstanding request, cycle-stamped milestones.
  int          relcnt = 0;
  int          acc_cyc = 0, start_due = -1, start_cyc = 0, vfrom = -1;
  bit          out_v = 1'b0, is_fpu = 1'b0, started = 1'b0;
  logic [2:0]  m_op = 3'd0;
  logic [31:0] m_a = 32'd0, m_b = 32'd0, e_data = 32'd0;
  logic [4:0]  m_tag = 5'd0;
  logic        e_err = 1'b0;

  always @(negedge clk) begin
    bit exp_ready, exp_valid;
    cyc++;
    if (!rst) begin
      chk("reset_ctrl", {52'd0, req_ready, fpu_start, fpu_op, resp_valid, resp_err, resp_tag}, 64'd0);
      chk("reset_fpu_n", {fpu_n1, fpu_n2}, 64'd0);
      chk("reset_resp_data", {32'd0, resp_data}, 64'd0);
      out_v  = 1'b0;
      relcnt = 0;
    end else begin
      exp_ready = (relcnt > 0) && !out_v;
      chk("req_ready", {63'd0, req_ready}, {63'd0, exp_ready});
      chk("fpu_start", {63'd0, fpu_start}, {63'd0, (out_v && is_fpu && cyc == start_due)});
      if (out_v) begin
        chk("fpu_op", {61'd0, fpu_op}, {61'd0, m_op});
        chk("fpu_n1_n2", {fpu_n1, fpu_n2}, {m_a, m_b});
      end
      exp_valid = out_v && (vfrom >= 0) && (cyc >= vfrom);
      chk("resp_valid", {63'd0, resp_valid}, {63'd0, exp_valid});
      if (resp_valid && exp_valid) begin
        chk("resp_data", {32'd0, resp_data}, {32'd0, e_data});
        chk("resp_tag_err", {58'd0, resp_tag, resp_err}, {58'd0, m_tag, e_err});
      end
      if (out_v && is_fpu) begin
        if (!started && start_due < 0 && cyc > acc_cyc && !fpu_busy) start_due = cyc + 1;
        if (cyc == start_due) begin
          started   = 1'b1;
          start_cyc = cyc;
        end
        if (started && vfrom < 0 && cyc > start_cyc) begin
          if (fpu_done) begin
            vfrom = cyc + 1;
          end
`ifdef FPU_ISSUE_TIMEOUT_EN
          else if (cyc == start_cyc + TMO - 1) begin
            vfrom  = cyc + 1;
            e_data = QNAN;
            e_err  = 1'b1;
          end
`endif
        end
      end
      if (exp_valid && resp_ready) begin
        out_v = 1'b0;
      end else if (req_valid && exp_ready) begin
        out_v     = 1'b1;
        m_op      = req_op;
        m_a       = req_a;
        m_b       = req_b;
        m_tag     = req_tag;
        acc_cyc   = cyc;
        start_due = -1;
        started   = 1'b0;
        is_fpu    = (req_op < 3'd4);
        e_err     = (req_op >= 3'd6);
        if (req_op >= 3'd6)      e_data = QNAN;
        else if (req_op == 3'd4) e_data = {~req_a[31], req_a[30:0]};
        else if (req_op == 3'd5) e_data = req_a;
        else                     e_data = fpu_fn(req_op, req_a, req_b);
        vfrom = is_fpu ? -1 : cyc + 1;
      end
      relcnt++;
    end
  end

  task automatic present(input int i);
    req_valid = 1'b1;
    req_op    = vt[i].op;
    req_a     = vt[i].a;
    req_b     = vt[i].b;
    req_tag   = vt[i].tag;
  endtask

  // Next request is presented as soon as the previous one is accepted.
  task automatic run_vectors(input int lo, input int hi);
    int  nxt = lo, cur = lo, done_n = 0, busy_left = 0, rr_left = 0, budget = 0;
    bit  acc, hs;
    @(posedge clk); #2;
    present(nxt);
    while (done_n < hi - lo && budget < 3000) begin
      @(negedge clk);
      acc = req_valid && req_ready;
      hs  = resp_valid && resp_ready;
      if (hs) begin
        chk("lit_data", {32'd0, resp_data}, {32'd0, vt[cur].exp});
        chk("lit_tag_err", {58'd0, resp_tag, resp_err}, {58'd0, vt[cur].tag, vt[cur].err});
        done_n++;
      end
      @(posedge clk); #2;
      budget++;
      if (acc) begin
        cur       = nxt;
        nxt++;
        busy_left = vt[cur].busy;
        rr_left   = vt[cur].rr;
        cur_lat   = vt[cur].lat;
        cur_stale = vt[cur].stale;
      end
      if (nxt < hi) present(nxt);
      else          req_valid = 1'b0;
      fpu_busy   = (busy_left > 0);
      stray_done = fpu_busy && vt[cur].stray;
      if (busy_left > 0) busy_left--;
      if (resp_valid && rr_left > 0) begin
        resp_ready = 1'b0;
        rr_left--;
      end else begin
        resp_ready = 1'b1;
      end
    end
    stray_done = 1'b0;
    fpu_busy   = 1'b0;
    chk("vectors_completed", 64'(done_n), 64'(hi - lo));
  endtask

  initial begin
    int k;
    //                op    a             b             tag lat bsy rr stray stale exp          err
    vt.push_back(mk(3'd0, 32'h40C00000, 32'h40000000, 5'd3,  3, 0, 0, 0, 0, 32'h41000000, 0));
    vt.push_back(mk(3'd2, 32'h40400000, 32'hC0000000, 5'd7,  2, 0, 0, 0, 0, 32'hC0C00000, 0));
    vt.push_back(mk(3'd3, 32'h41100000, 32'h40400000, 5'd8,  6, 0, 0, 0, 0, 32'h40400000, 0));
    vt.push_back(mk(3'd4, 32'h40400000, 32'h00000000, 5'd9,  1, 0, 0, 0, 0, 32'hC0400000, 0));
    vt.push_back(mk(3'd5, 32'h3FC00000, 32'h12345678, 5'd10, 1, 0, 0, 0, 0, 32'h3FC00000, 0));
    vt.push_back(mk(3'd7, 32'h11111111, 32'h22222222, 5'd11, 1, 0, 0, 0, 0, 32'h7FC00000, 1));
    vt.push_back(mk(3'd1, 32'h40C00000, 32'h40000000, 5'd31, 1, 5, 0, 1, 1, 32'h40800000, 0));
    vt.push_back(mk(3'd4, 32'h80000000, 32'h00000000, 5'd0,  1, 0, 4, 0, 0, 32'h00000000, 0));
    vt.push_back(mk(3'd6, 32'h3F800000, 32'h3F800000, 5'd1,  1, 0, 2, 0, 0, 32'h7FC00000, 1));
    vt.push_back(mk(3'd0, 32'h40C00000, 32'h40000000, 5'd2,  1, 2, 4, 0, 0, 32'h41000000, 0));
    vt.push_back(mk(3'd0, 32'h40C00000, 32'h40000000, 5'd4,  4, 0, 0, 0, 0, 32'h41000000, 0));
    vt.push_back(mk(3'd0, 32'h40C00000, 32'h40000000, 5'd5,  0, 0, 0, 0, 0, 32'h7FC00000, 1));

    repeat (3) @(negedge clk);
    @(posedge clk); #2;
    rst = 1'b1;

    run_vectors(0, 10);

    // Reset while waiting for a long divide.
    cur_lat = 40; cur_stale = 1'b0;
    @(posedge clk); #2;
    present(2);
    k = 0;
    do begin @(negedge clk); k++; end while (!(req_valid && req_ready) && k < 50);
    @(posedge clk); #2;
    req_valid = 1'b0;
    k = 0;
    do begin @(negedge clk); k++; end while (!fpu_start && k < 50);
    chk("start_before_reset", {63'd0, fpu_start}, 64'd1);
    repeat (3) @(negedge clk);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    chk("async_reset_now", {60'd0, resp_valid, req_ready, fpu_start, fpu_n1 == 32'd0}, 64'd1);
    repeat (2) @(negedge clk);
    @(posedge clk); #2;
    rst = 1'b1;

    run_vectors(10, 11);
`ifdef FPU_ISSUE_TIMEOUT_EN
    run_vectors(11, 12);
`endif

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout cyc=%0d got=running expected=finished", cyc);
    $fatal(1, "global timeout");
  end

endmodule
`default_nettype wire

// File: doc/fpu_issue_ctrl.md
Name: fpu_issue_ctrl

Overview:
Requester-side controller for the FPU start/done/busy handshake, sitting between the RV32IMF execute stage and FPU_Top.
- Accepts one F-extension operation per request from the core over a valid/ready port.
- Drives FPU_Top's start/fpu_op/N1/N2, waits for done, captures result.
- Returns result plus destination tag to writeback over a second valid/ready port.
- Holds the core off while an operation is outstanding; fneg.s/fmv can optionally be completed locally without occupying the FPU.

Parameters:
TAG_W, 5, width of destination-register tag carried alongside the request.
LOCAL_SIGN_OPS, 1, 1 = ops 100 (fneg.s) and 101 (fmv) complete locally without using the FPU; 0 = all legal ops are issued to the FPU.
TIMEOUT_CYCLES, 256, watchdog limit in cycles, used only when FPU_ISSUE_TIMEOUT_EN is defined.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-low reset.
req_valid  input  1  core presents an operation.
req_ready  output  1  controller can accept an operation.
req_op  input  3  000 add, 001 sub, 010 mul, 011 div, 100 fneg.s, 101 fmv; 110/111 illegal.
req_a  input  32  operand 1 (IEEE-754 single).
req_b  input  32  operand 2.
req_tag  input  TAG_W  destination register tag.
fpu_start  output  1  one-cycle start pulse to FPU.
fpu_op  output  3  operation code to FPU.
fpu_n1  output  32  operand 1 to FPU.
fpu_n2  output  32  operand 2 to FPU.
fpu_result  input  32  FPU result.
fpu_done  input  1  FPU completion.
fpu_busy  input  1  FPU busy.
resp_valid  output  1  result available.
resp_ready  input  1  writeback accepts result.
resp_data  output  32  result value.
resp_tag  output  TAG_W  tag echoed from the request.
resp_err  output  1  illegal op or timeout; valid only with resp_valid.

Behaviour:
- All outputs are registered.
- Reset values (rst low, asynchronous): state IDLE; req_ready=0 during reset and 1 from the first clock after release; fpu_start=0; fpu_op=0; fpu_n1=0; fpu_n2=0; resp_valid=0; resp_data=0; resp_tag=0; resp_err=0.
- States:
  - IDLE: req_ready=1. On req_valid&&req_ready, latch op/a/b/tag into fpu_op/fpu_n1/fpu_n2 and the tag register; req_ready drops the next cycle.
    - Illegal op -> RESP with resp_data=32'h7FC00000, resp_err=1.
    - LOCAL_SIGN_OPS=1 and op=100 -> RESP with resp_data={~a[31],a[30:0]}.
    - LOCAL_SIGN_OPS=1 and op=101 -> RESP with resp_data=a.
    - Otherwise -> ISSUE.
  - ISSUE: while fpu_busy=1, stay and keep fpu_start=0. When fpu_busy=0, assert fpu_start for exactly one cycle -> WAIT.
  - WAIT: fpu_start=0; fpu_op/n1/n2 held stable. fpu_done is ignored in the cycle fpu_start is high, which prevents capturing a stale done. On the first later cycle with fpu_done=1, capture fpu_result into resp_data, resp_err=0 -> RESP.
  - RESP: resp_valid=1; data, tag and err held until resp_ready=1. The transfer completes on resp_valid&&resp_ready -> IDLE and resp_valid clears next cycle.
- Latency:
  - FPU ops: request handshake to resp_valid = 1 (ISSUE) + FPU latency + 1 (capture).
  - Local/illegal ops: resp_valid rises 1 cycle after the request handshake.
- Throughput: one outstanding operation; no new request is accepted until the response handshake completes.
- Operand/op registers to the FPU change only in IDLE on acceptance.
- fpu_done arriving while in IDLE, ISSUE or RESP is ignored.
- resp_ready held high permanently: the response is accepted the first cycle resp_valid=1.
- Reset mid-operation returns to IDLE immediately and drops any outstanding result. FPU_Top is reset by the same system reset.

Optional Feature:
FPU_ISSUE_TIMEOUT_EN:
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES without fpu_done, go to RESP with resp_data=32'h7FC00000, resp_err=1.
  - A late fpu_done is ignored.
- Not defined:
  - No counter is built.
  - WAIT persists until fpu_done; resp_err is set only for illegal ops.

Test Plan:
- Add: req_op=000, a=40C00000, b=40000000, tag=3 -> one fpu_start pulse with fpu_op=000; resp_data=41000000, resp_tag=3, resp_err=0.
- Back-to-back: mul 40400000*C0000000 then div 41100000/40400000, resp_ready always 1 -> responses C0C00000 then 40400000 in order; req_ready=0 throughout the first op.
- Local op, LOCAL_SIGN_OPS=1: fneg a=40400000 -> resp_data=C0400000 one cycle after acceptance, no fpu_start. fmv a=3FC00000 -> 3FC00000.
- Illegal op=111 -> resp_data=7FC00000, resp_err=1, no fpu_start.
- Backpressure and busy: fpu_busy high 5 cycles before issue -> fpu_start delayed until busy low. resp_ready low 4 cycles -> resp_valid/data/tag stable, no new request accepted.
- Reset/timeout: assert rst during WAIT -> all outputs at reset values, IDLE. With FPU_ISSUE_TIMEOUT_EN and TIMEOUT_CYCLES=16, FPU never asserts done -> resp_err=1, resp_data=7FC00000 after 16 WAIT cycles.
